// File: rtl/spi_sequencer.sv
// rtl/spi_sequencer.sv - SPI command FIFO with guarded one-at-a-time issue; optional drain irq via SPI_SEQUENCER_IRQ_EN
module spi_sequencer #(
  parameter int DEPTH    = 16,
  parameter int XFER_GAP = 480,
  parameter int PWR_GAP  = 6250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [9:0]  wr_data,
  input  logic        clr,
  output logic        spi_start,
  output logic [9:0]  spi_din,
  output logic [31:0] status,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  // count field in status never shrinks below 5 bits so irq_pend stays at bit 9 for small queues
  localparam int FW = (CW > 5) ? CW : 5;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [22:0]   XFER_LD  = 23'(XFER_GAP - 1);
  localparam logic [22:0]   PWR_LD   = 23'(PWR_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [9:0]    mem_q [DEPTH];
  logic [9:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [22:0]   gap_cnt_q, gap_cnt_d;
  logic          spi_start_q, spi_start_d;
  logic [9:0]    spi_din_q, spi_din_d;
  logic          irq_pend;

  logic empty, full, pop, push, drop;

`ifdef SPI_SEQUENCER_IRQ_EN
  logic irq_q, irq_d;
`endif

  // FIFO bookkeeping: push/pop/drop decisions, pointers, occupancy and sticky overflow
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_CNT);
    // an issue committed just before a clr must not underflow the emptied queue
    pop   = (state_q == S_ISSUE) && !empty;
    push  = wr_en && !clr && (!full || pop);
    drop  = wr_en && !clr && full && !pop;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;

    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_data;
  end

  // issue scheduler: IDLE -> ISSUE (start pulse) -> GAP (guard countdown) -> IDLE
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    spi_start_d = 1'b0;
    spi_din_d   = spi_din_q;
`ifdef SPI_SEQUENCER_IRQ_EN
    irq_d       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d     = S_ISSUE;
          spi_start_d = 1'b1;
          spi_din_d   = mem_q[rd_ptr_q];
        end
      end
      S_ISSUE: begin
        // the latched issued word decides the guard length
        gap_cnt_d = spi_din_q[9] ? PWR_LD : XFER_LD;
        state_d   = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
`ifdef SPI_SEQUENCER_IRQ_EN
          irq_d   = empty;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q - 23'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, control and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      gap_cnt_q   <= '0;
      spi_start_q <= 1'b0;
      spi_din_q   <= '0;
`ifdef SPI_SEQUENCER_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      gap_cnt_q   <= gap_cnt_d;
      spi_start_q <= spi_start_d;
      spi_din_q   <= spi_din_d;
`ifdef SPI_SEQUENCER_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  // queue storage; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef SPI_SEQUENCER_IRQ_EN
  assign irq      = irq_q;
  assign irq_pend = irq_q;
`else
  assign irq      = 1'b0;
  assign irq_pend = 1'b0;
`endif

  assign spi_start = spi_start_q;
  assign spi_din   = spi_din_q;

  // status word for the CPU read mux
  always_comb begin
    status            = '0;
    status[0]         = (state_q != S_IDLE);
    status[1]         = empty;
    status[2]         = full;
    status[3]         = ovf_q;
    status[4 +: FW]   = FW'(count_q);
    status[4 + FW]    = irq_pend;
  end

endmodule

// File: tb/tb_spi_sequencer.sv
// tb/tb_spi_sequencer.sv - directed self-checking bench for spi_sequencer (DEPTH=4, XFER_GAP=4, PWR_GAP=8)
module tb_spi_sequencer;

`ifdef SPI_SEQUENCER_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [9:0]  wr_data;
  logic        clr;
  logic        spi_start;
  logic [9:0]  spi_din;
  logic [31:0] status;
  logic        irq;

  spi_sequencer #(.DEPTH(4), .XFER_GAP(4), .PWR_GAP(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .clr       (clr),
    .spi_start (spi_start),
    .spi_din   (spi_din),
    .status    (status),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         st_cyc[$];
  logic [9:0] st_din[$];
  int         irq_cyc[$];
  int         busy_cnt;
  int         n_vec  = 0;
  int         n_miss = 0;
  int         e0, c0;
  bit         found;

  // event recorder sampling away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (spi_start) begin
        st_cyc.push_back(cyc);
        st_din.push_back(spi_din);
      end
      if (irq) irq_cyc.push_back(cyc);
      if (status[0]) busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_din.delete();
    irq_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
  endtask

  task automatic put(input logic [9:0] d, output int e);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    e = cyc;
  endtask

  initial begin
    int e;

    // reset state and quiet hold
    do_reset();
    @(negedge clk);
    chk("rst_din", spi_din, 10'h000);
    chk("rst_irq", irq, 1'b0);
    for (int k = 0; k < 20; k++) begin
      chk("idle_status", status, 32'h2);
      chk("idle_start", spi_start, 1'b0);
      @(negedge clk);
    end

    // single byte command: latency, busy span, drain irq
    do_reset();
    put(10'h0A5, e0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (cyc == e0 + 6) chk("irq_status", status, (IRQ_ON != 0) ? 32'h202 : 32'h2);
    end
    chk("single_n", st_cyc.size(), 1);
    chk("single_lat", (st_cyc.size() > 0) ? st_cyc[0] : -1, e0 + 1);
    chk("single_din", (st_din.size() > 0) ? st_din[0] : 10'h3FF, 10'h0A5);
    chk("single_busy", busy_cnt, 5);
    chk("single_irq_n", irq_cyc.size(), IRQ_ON);
    chk("single_irq_at", (irq_cyc.size() > 0) ? irq_cyc[0] : -1, (IRQ_ON != 0) ? e0 + 6 : -1);
    chk("single_end", status, 32'h2);

    // power-on command followed by a byte: long gap spacing
    do_reset();
    put(10'h200, e0);
    put(10'h123, e);
    repeat (25) @(negedge clk);
    chk("pwr_n", st_cyc.size(), 2);
    chk("pwr_first", (st_cyc.size() > 0) ? st_cyc[0] : -1, e0 + 1);
    chk("pwr_space", (st_cyc.size() > 1) ? st_cyc[1] - st_cyc[0] : -1, 10);
    chk("pwr_din0", (st_din.size() > 0) ? st_din[0] : 10'h3FF, 10'h200);
    chk("pwr_din1", (st_din.size() > 1) ? st_din[1] : 10'h3FF, 10'h123);

    // six writes back to back: five accepted, sixth overflows
    do_reset();
    for (int i = 1; i <= 6; i++) put(10'(i), e);
    @(negedge clk);
    chk("ovf_status", status, 32'h4D);
    repeat (40) @(negedge clk);
    chk("ovf_n", st_cyc.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("ovf_din", (st_din.size() > i) ? st_din[i] : 10'h3FF, 10'(i + 1));
    chk("ovf_end", status, 32'hA);

    // write on the pop cycle of a full queue
    do_reset();
    for (int i = 0; i < 5; i++) put(10'h10 + 10'(i), e);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (spi_start) found = 1'b1;
    end
    chk("full_pop_seen", found, 1'b1);
    chk("full_pop_pre", status, 32'h45);
    wr_en   = 1'b1;
    wr_data = 10'h15;
    @(posedge clk);
    #1 wr_en = 1'b0;
    @(negedge clk);
    chk("full_pop_post", status, 32'h45);
    repeat (40) @(negedge clk);
    chk("full_pop_n", st_cyc.size(), 6);
    chk("full_pop_last", (st_din.size() > 5) ? st_din[5] : 10'h3FF, 10'h15);
    chk("full_pop_end", status, 32'h2);

    // clr mid-gap with three queued, simultaneous write dropped
    do_reset();
    for (int i = 0; i < 4; i++) put(10'h31 + 10'(i), e);
    @(negedge clk);
    chk("clr_pre", status, 32'h31);
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 10'h3FF;
    @(posedge clk);
    #1;
    clr   = 1'b0;
    wr_en = 1'b0;
    c0    = cyc;
    @(negedge clk);
    chk("clr_post", status, 32'h3);
    repeat (20) @(negedge clk);
    chk("clr_n", st_cyc.size(), 1);
    chk("clr_din", (st_din.size() > 0) ? st_din[0] : 10'h3FF, 10'h31);
    chk("clr_irq_n", irq_cyc.size(), IRQ_ON);
    chk("clr_irq_at", (irq_cyc.size() > 0) ? irq_cyc[0] : -1, (IRQ_ON != 0) ? c0 + 2 : -1);
    chk("clr_end", status, 32'h2);

    // reset during a power-on gap aborts it
    do_reset();
    put(10'h200, e);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gap_status", status, 32'h2);
    chk("rst_gap_din", spi_din, 10'h000);
    chk("rst_gap_start", spi_start, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1 clear_log();
    put(10'h0AA, e0);
    repeat (3) @(negedge clk);
    chk("rst_gap_n", st_cyc.size(), 1);
    chk("rst_gap_lat", (st_cyc.size() > 0) ? st_cyc[0] : -1, e0 + 1);
    chk("rst_gap_din2", (st_din.size() > 0) ? st_din[0] : 10'h3FF, 10'h0AA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
